// File: rtl/rf_seq_pkg.sv
// ---------------------------------------------------------------------------
// rf_seq_pkg
// Shared definitions for the register-file operation sequencer and the ALU
// it drives.
//   seq_state_e : sequencer FSM states (CLEAR, IDLE, READ, EXEC, WB)
//   ALU_*       : ALU control codes carried on cmd_aluctrl / alu_ctrl
// ---------------------------------------------------------------------------
package rf_seq_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } seq_state_e;

    localparam int ALU_CTRL_WIDTH = 3;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'd5;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL = 3'd6;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL = 3'd7;

endpackage

// File: rtl/rf_op_sequencer.sv
// ---------------------------------------------------------------------------
// rf_op_sequencer
// Multicycle controller that runs one R/I-type op at a time through an
// external 2**ADDR_WIDTH x DATA_WIDTH register file (registered reads) and a
// combinational ALU.  Right after reset it sweeps every register to zero,
// since the register file itself has no reset.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready           op handshake from decode
//   cmd_rs1, cmd_rs2, cmd_rd        source / destination register numbers
//   cmd_imm, cmd_alusrc             immediate and operand-2 select (1 = imm)
//   cmd_aluctrl                     ALU operation code
//   rf_rs1, rf_rs2                  register file read addresses
//   rf_rd, rf_en, rf_din            register file write port
//   rf_rd1, rf_rd2                  register file read data (1-cycle latency)
//   alu_op1, alu_op2, alu_ctrl      ALU operands and control
//   alu_result                      ALU result
//   done                            one-cycle pulse in the write-back cycle
//   init_done                       high once the zero sweep has finished
// ---------------------------------------------------------------------------
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int CTRL_WIDTH     = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_rs1,
    input  logic [ADDR_WIDTH-1:0] cmd_rs2,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    input  logic                  cmd_alusrc,
    input  logic [CTRL_WIDTH-1:0] cmd_aluctrl,
    output logic [ADDR_WIDTH-1:0] rf_rs1,
    output logic [ADDR_WIDTH-1:0] rf_rs2,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic                  rf_en,
    output logic [DATA_WIDTH-1:0] rf_din,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_rd2,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  done,
    output logic                  init_done
);

    localparam seq_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    seq_state_e            r_state;
    seq_state_e            w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_alusrc;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  w_clr_last;
    logic                  w_accept;

    assign w_clr_last = (r_clr_cnt == {ADDR_WIDTH{1'b1}});
    assign w_accept   = cmd_valid && cmd_ready;
    assign init_done  = r_init_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and all datapath/handshake outputs.  While rst_n is low the
    // outputs are forced to zero so that CLEAR (the reset state) does not
    // drive a write before reset is released.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rf_rs1       = '0;
        rf_rs2       = '0;
        rf_rd        = '0;
        rf_en        = 1'b0;
        rf_din       = '0;
        alu_op1      = '0;
        alu_op2      = '0;
        alu_ctrl     = '0;
        done         = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_CLEAR: begin
                    rf_en = 1'b1;
                    rf_rd = r_clr_cnt;
                    if (w_clr_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        w_state_next = ST_READ;
                    end
                end
                ST_READ: begin
                    rf_rs1       = r_rs1;
                    rf_rs2       = r_rs2;
                    w_state_next = ST_EXEC;
                end
                ST_EXEC: begin
                    alu_op1      = rf_rd1;
                    alu_op2      = r_alusrc ? r_imm : rf_rd2;
                    alu_ctrl     = r_ctrl;
                    w_state_next = ST_WB;
                end
                ST_WB: begin
                    rf_rd     = r_rd;
                    rf_din    = r_result;
                    // x0 is hard-wired to zero, so its write is dropped.
                    rf_en     = (r_rd != '0);
                    done      = 1'b1;
                    cmd_ready = 1'b1;
                    w_state_next = cmd_valid ? ST_READ : ST_IDLE;
                end
                default: begin
                    w_state_next = RESET_STATE;
                end
            endcase
        end
    end

    // Sweep counter holds at the last register instead of wrapping; it is
    // only meaningful in CLEAR and restarts from zero on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt   <= '0;
            r_init_done <= (CLEAR_ON_RESET == 0);
        end else if (r_state == ST_CLEAR) begin
            if (w_clr_last) begin
                r_init_done <= 1'b1;
            end else begin
                r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Command fields are captured on the handshake and held for the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_alusrc <= 1'b0;
            r_ctrl   <= '0;
        end else if (w_accept) begin
            r_rs1    <= cmd_rs1;
            r_rs2    <= cmd_rs2;
            r_rd     <= cmd_rd;
            r_imm    <= cmd_imm;
            r_alusrc <= cmd_alusrc;
            r_ctrl   <= cmd_aluctrl;
        end
    end

    // ALU result is registered at the end of EXEC and written back in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (r_state == ST_EXEC) begin
            r_result <= alu_result;
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_op_sequencer
// Bench for rf_op_sequencer.  Provides a behavioural register file with
// registered reads and a combinational ALU, drives directed ops, and checks
// every write-back against a scoreboard filled at handshake time.
// ---------------------------------------------------------------------------
module tb_rf_op_sequencer;
    import rf_seq_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 3;
    localparam int NREG = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_rs1;
    logic [AW-1:0] cmd_rs2;
    logic [AW-1:0] cmd_rd;
    logic [DW-1:0] cmd_imm;
    logic          cmd_alusrc;
    logic [CW-1:0] cmd_aluctrl;
    logic [AW-1:0] rf_rs1;
    logic [AW-1:0] rf_rs2;
    logic [AW-1:0] rf_rd;
    logic          rf_en;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic [DW-1:0] alu_op1;
    logic [DW-1:0] alu_op2;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          done;
    logic          init_done;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            cycle;
    } expect_t;

    expect_t       sbQueue[$];
    logic [DW-1:0] regMem [NREG];
    logic [DW-1:0] shadowReg [NREG];
    int            cycleCnt  = 0;
    int            doneCount = 0;
    int            cmpCount  = 0;
    int            errCount  = 0;

    always #5 clk = ~clk;

    rf_op_sequencer #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CTRL_WIDTH    (CW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd     (cmd_rd),
        .cmd_imm    (cmd_imm),
        .cmd_alusrc (cmd_alusrc),
        .cmd_aluctrl(cmd_aluctrl),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rd      (rf_rd),
        .rf_en      (rf_en),
        .rf_din     (rf_din),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .done       (done),
        .init_done  (init_done)
    );

    function automatic logic [DW-1:0] aluModel(input logic [CW-1:0] ctrl,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (ctrl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            ALU_SLL: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Behavioural register file: registered reads, write on the same edge.
    always @(posedge clk) begin
        rf_rd1 <= regMem[rf_rs1];
        rf_rd2 <= regMem[rf_rs2];
        if (rf_en) begin
            regMem[rf_rd] <= rf_din;
        end
    end

    assign alu_result = aluModel(alu_ctrl, alu_op1, alu_op2);

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: expected write-backs are pushed on each handshake using the
    // bench's own view of register contents, and popped on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbQueue.delete();
            for (int i = 0; i < NREG; i++) shadowReg[i] = '0;
        end else begin
            if (done) begin
                doneCount++;
                if (sbQueue.size() == 0) begin
                    checkOutput("doneWithoutOp", DW'(sbQueue.size()), DW'(1));
                end else begin
                    expect_t e;
                    e = sbQueue.pop_front();
                    checkOutput("wbAddr",    DW'(rf_rd),    DW'(e.rd));
                    checkOutput("wbData",    rf_din,        e.data);
                    checkOutput("wbEnable",  DW'(rf_en),    DW'(e.rd != '0));
                    checkOutput("wbLatency", DW'(cycleCnt), DW'(e.cycle + 3));
                end
            end
            if (cmd_valid && cmd_ready) begin
                expect_t       e;
                logic [DW-1:0] op2;
                op2     = cmd_alusrc ? cmd_imm : shadowReg[cmd_rs2];
                e.rd    = cmd_rd;
                e.data  = aluModel(cmd_aluctrl, shadowReg[cmd_rs1], op2);
                e.cycle = cycleCnt;
                sbQueue.push_back(e);
                if (cmd_rd != '0) shadowReg[cmd_rd] = e.data;
            end
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic [AW-1:0] rd, input logic [DW-1:0] imm,
                                 input logic alusrc, input logic [CW-1:0] ctrl);
        int waitCycles = 0;
        cmd_rs1     = rs1;
        cmd_rs2     = rs2;
        cmd_rd      = rd;
        cmd_imm     = imm;
        cmd_alusrc  = alusrc;
        cmd_aluctrl = ctrl;
        cmd_valid   = 1'b1;
        while (!cmd_ready && waitCycles < 100) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("handshakeReady", DW'(cmd_ready), DW'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic sweepCheck();
        for (int i = 0; i < NREG; i++) begin
            checkOutput("sweepEn",    DW'(rf_en),     DW'(1));
            checkOutput("sweepAddr",  DW'(rf_rd),     DW'(i));
            checkOutput("sweepData",  rf_din,         DW'(0));
            checkOutput("sweepReady", DW'(cmd_ready), DW'(0));
            checkOutput("sweepInit",  DW'(init_done), DW'(0));
            @(posedge clk); #1;
        end
        checkOutput("initDoneHigh", DW'(init_done), DW'(1));
        checkOutput("idleWriteOff", DW'(rf_en),     DW'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_rs1     = '0;
        cmd_rs2     = '0;
        cmd_rd      = '0;
        cmd_imm     = '0;
        cmd_alusrc  = 1'b0;
        cmd_aluctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetEn",    DW'(rf_en),     DW'(0));
        checkOutput("resetAddr",  DW'(rf_rd),     DW'(0));
        checkOutput("resetReady", DW'(cmd_ready), DW'(0));
        checkOutput("resetDone",  DW'(done),      DW'(0));
        checkOutput("resetInit",  DW'(init_done), DW'(0));

        // x1 = x0 + 5, held valid through the whole sweep.
        cmd_rs1     = 5'd0;
        cmd_rs2     = 5'd0;
        cmd_rd      = 5'd1;
        cmd_imm     = 32'd5;
        cmd_alusrc  = 1'b1;
        cmd_aluctrl = ALU_ADD;
        cmd_valid   = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        sweepCheck();
        checkOutput("idleReady", DW'(cmd_ready), DW'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("readNotReady", DW'(cmd_ready), DW'(0));

        // ADDI x3 = x1 + 7, then ADD x4 = x3 + x1 back-to-back.
        applyStimulus(5'd1, 5'd9, 5'd3, 32'd7, 1'b1, ALU_ADD);
        checkOutput("readRs1", DW'(rf_rs1), DW'(1));
        checkOutput("readRs2", DW'(rf_rs2), DW'(9));
        applyStimulus(5'd3, 5'd1, 5'd4, 32'd0, 1'b0, ALU_ADD);
        @(posedge clk); #1;
        checkOutput("execOp1Raw",   alu_op1,         DW'(12));
        checkOutput("execOp2",      alu_op2,         DW'(5));
        checkOutput("execCtrl",     DW'(alu_ctrl),   DW'(ALU_ADD));
        checkOutput("execNotReady", DW'(cmd_ready),  DW'(0));
        checkOutput("execWriteOff", DW'(rf_en),      DW'(0));

        applyStimulus(5'd3, 5'd4, 5'd0, 32'd0, 1'b0, ALU_ADD);
        applyStimulus(5'd4, 5'd1, 5'd6, 32'd0, 1'b0, ALU_SUB);
        applyStimulus(5'd0, 5'd1, 5'd5, 32'd0, 1'b0, ALU_OR);
        applyStimulus(5'd4, 5'd0, 5'd31, 32'hFFFF_FFFF, 1'b1, ALU_ADD);
        applyStimulus(5'd31, 5'd6, 5'd7, 32'd0, 1'b0, ALU_XOR);
        applyStimulus(5'd6, 5'd0, 5'd8, 32'hFFFF_FFF0, 1'b1, ALU_SLT);

        // Reset during EXEC drops the op and restarts the sweep.
        applyStimulus(5'd1, 5'd0, 5'd9, 32'd100, 1'b1, ALU_ADD);
        @(posedge clk); #1;
        checkOutput("preResetOp1", alu_op1, DW'(5));
        rst_n = 1'b0;
        #1;
        checkOutput("midResetEn",    DW'(rf_en),     DW'(0));
        checkOutput("midResetDone",  DW'(done),      DW'(0));
        checkOutput("midResetOp1",   alu_op1,        DW'(0));
        checkOutput("midResetOp2",   alu_op2,        DW'(0));
        checkOutput("midResetCtrl",  DW'(alu_ctrl),  DW'(0));
        checkOutput("midResetReady", DW'(cmd_ready), DW'(0));
        checkOutput("midResetInit",  DW'(init_done), DW'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        sweepCheck();

        applyStimulus(5'd1, 5'd0, 5'd2, 32'd3, 1'b1, ALU_ADD);
        applyStimulus(5'd2, 5'd2, 5'd10, 32'd0, 1'b0, ALU_SLL);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("queueDrained", DW'(sbQueue.size()), DW'(0));
        checkOutput("opsCompleted", DW'(doneCount),      DW'(11));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
